// File: rtl/mem_ls_pkg.sv
// Shared types and helpers for the load/store control FSM.
// States, default opcodes and an instruction field extractor.
package mem_ls_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MAR,
    S_ST_DRV,
    S_ST_WR,
    S_LD_RD,
    S_LD_CAP,
    S_LD_WB,
    S_DONE
  } ls_state_e;

  localparam logic [3:0] LS_OP_LOAD  = 4'b0011;
  localparam logic [3:0] LS_OP_STORE = 4'b0100;

  // fw-bit field whose top bit sits at msb
  function automatic logic [31:0] ls_field(
    input logic [63:0] w,
    input int          msb,
    input int          fw
  );
    logic [63:0] m;
    m = (64'd1 << fw) - 64'd1;
    return 32'((w >> (msb - fw + 1)) & m);
  endfunction

endpackage

// File: rtl/mem_ls_ctrl_if.sv
// Instruction handshake and datapath strobe bundle
// between the sequencer and its surroundings.
interface mem_ls_ctrl_if #(
  parameter int IW   = 16,
  parameter int NREG = 4
);
  logic            start;
  logic [IW-1:0]   instr;
  logic            mem_ready;
  logic            pc_inc;
  logic [NREG-1:0] reg_out;
  logic [NREG-1:0] reg_in;
  logic            mar_en;
  logic            mem_en;
  logic            mem_rw;
  logic            mdr_en_read;
  logic            mdr_en_write;
  logic            mdr_out;
  logic            busy;
  logic            done;
  logic            ill;
  logic            err;

  modport master (
    output start, instr, mem_ready,
    input  pc_inc, reg_out, reg_in,
    input  mar_en, mem_en, mem_rw,
    input  mdr_en_read, mdr_en_write,
    input  mdr_out, busy, done, ill, err
  );

  modport slave (
    input  start, instr, mem_ready,
    output pc_inc, reg_out, reg_in,
    output mar_en, mem_en, mem_rw,
    output mdr_en_read, mdr_en_write,
    output mdr_out, busy, done, ill, err
  );
endinterface

// File: rtl/ls_reg_decode.sv
// Register field to one-hot select; valid when the
// field names an existing register.
module ls_reg_decode #(
  parameter int FW   = 6,
  parameter int NREG = 4
) (
  input  logic [FW-1:0]   field,
  input  logic            en,
  output logic [NREG-1:0] onehot,
  output logic            valid
);

  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (field == FW'(i)) begin
        valid     = 1'b1;
        onehot[i] = en;
      end
    end
  end

endmodule

// File: rtl/mem_ls_ctrl.sv
// Load/store sequencer for the bus datapath.
// Optional mem_ready timeout: define LS_TIMEOUT_EN.
module mem_ls_ctrl
  import mem_ls_pkg::*;
#(
  parameter int             IW       = 16,
  parameter int             OPW      = 4,
  parameter int             FW       = 6,
  parameter int             NREG     = 4,
  parameter logic [OPW-1:0] OP_LOAD  = LS_OP_LOAD,
  parameter logic [OPW-1:0] OP_STORE = LS_OP_STORE,
  parameter int             TIMEOUT  = 15
) (
  input logic          clk,
  input logic          rst,
  mem_ls_ctrl_if.slave bus
);

  ls_state_e       state_q, state_d;
  logic [OPW-1:0]  op;
  logic [FW-1:0]   f1, f2;
  logic [NREG-1:0] oh1, oh2;
  logic [NREG-1:0] p1_q, p2_q;
  logic            v1, v2;
  logic            ld_q, ill_q, err_q;
  logic            is_ld, is_st, legal;
  logic            idle, accept, reject;
  logic            waiting, to_hit;

  assign op = OPW'(ls_field(64'(bus.instr), IW - 1, OPW));
  assign f1 = FW'(ls_field(64'(bus.instr), IW - OPW - 1, FW));
  assign f2 = FW'(ls_field(64'(bus.instr), FW - 1, FW));

  assign idle = (state_q == S_IDLE);

  ls_reg_decode #(.FW(FW), .NREG(NREG)) u_p1 (
    .field (f1),
    .en    (idle),
    .onehot(oh1),
    .valid (v1)
  );

  ls_reg_decode #(.FW(FW), .NREG(NREG)) u_p2 (
    .field (f2),
    .en    (idle),
    .onehot(oh2),
    .valid (v2)
  );

  assign is_ld  = (op == OP_LOAD);
  assign is_st  = (op == OP_STORE);
  assign legal  = (is_ld | is_st) & v1 & v2;
  assign accept = idle & bus.start & legal;
  assign reject = idle & bus.start & ~legal;

  assign waiting = (state_q == S_ST_WR) |
                   (state_q == S_LD_RD);

`ifdef LS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  // cleared in the state just before each wait state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == S_MAR ||
                 state_q == S_ST_DRV) begin
      cnt_q <= '0;
    end else if (waiting && !bus.mem_ready) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign to_hit = waiting & ~bus.mem_ready &
                  (cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ld_q    <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= reject;
      if (accept) begin
        ld_q  <= is_ld;
        p1_q  <= oh1;
        p2_q  <= oh2;
        err_q <= 1'b0;
      end else if (to_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_FETCH;
      S_FETCH:  state_d = S_MAR;
      S_MAR:    state_d = ld_q ? S_LD_RD : S_ST_DRV;
      S_ST_DRV: state_d = S_ST_WR;
      S_ST_WR: begin
        if (bus.mem_ready)  state_d = S_DONE;
        else if (to_hit)    state_d = S_DONE;
      end
      S_LD_RD: begin
        if (bus.mem_ready)  state_d = S_LD_CAP;
        else if (to_hit)    state_d = S_DONE;
      end
      S_LD_CAP: state_d = S_LD_WB;
      S_LD_WB:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.reg_out = '0;
    unique case (1'b1)
      state_q == S_FETCH,
      state_q == S_MAR:    bus.reg_out = p2_q;
      state_q == S_ST_DRV: bus.reg_out = p1_q;
      default:             bus.reg_out = '0;
    endcase
  end

  assign bus.reg_in = (state_q == S_LD_WB) ? p1_q : '0;

  assign bus.pc_inc       = (state_q == S_FETCH);
  assign bus.mar_en       = (state_q == S_MAR);
  assign bus.mdr_en_write = (state_q == S_ST_DRV);
  assign bus.mdr_en_read  = (state_q == S_LD_CAP);
  assign bus.mdr_out      = (state_q == S_LD_WB);
  assign bus.mem_rw       = (state_q == S_LD_RD) |
                            (state_q == S_LD_CAP);
  assign bus.mem_en       = bus.mem_rw |
                            (state_q == S_ST_WR);
  assign bus.busy         = ~idle;
  assign bus.done         = (state_q == S_DONE);
  assign bus.ill          = ill_q;
  assign bus.err          = bus.done & err_q;

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// Randomised load/store bench: each instruction is expanded
// into its expected per-cycle strobe trace and compared.
module tb_mem_ls_ctrl;

  localparam int NREG    = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_ls_ctrl_if #(.IW(16), .NREG(NREG)) bus ();

  mem_ls_ctrl #(
    .IW      (16),
    .OPW     (4),
    .FW      (6),
    .NREG    (NREG),
    .OP_LOAD (4'b0011),
    .OP_STORE(4'b0100),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [17:0] exp_q[$];
  bit          rdy_q[$];
  bit          sok_q[$];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] obs();
    return {bus.pc_inc, bus.reg_out, bus.reg_in,
            bus.mar_en, bus.mem_en, bus.mem_rw,
            bus.mdr_en_read, bus.mdr_en_write,
            bus.mdr_out, bus.busy, bus.done,
            bus.ill, bus.err};
  endfunction

  // fields: pc, rout, rin, mar, men, rw, mdrr, mdrw, mdro, busy, done, ill, err
  function automatic logic [17:0] mk(
    bit pc, logic [3:0] ro, logic [3:0] ri,
    bit ma, bit me, bit rw, bit dr, bit dw,
    bit mo, bit bs, bit dn, bit il, bit er
  );
    return {pc, ro, ri, ma, me, rw, dr, dw,
            mo, bs, dn, il, er};
  endfunction

  task automatic push(logic [17:0] e, bit r, bit s);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    sok_q.push_back(s);
  endtask

  // expected trace; w = mem_ready=0 cycles before ready
  task automatic plan(input logic [15:0] ins, input int w);
    int op, a, b, nw;
    bit to, rnd;
    logic [3:0] oa, ob;
    op = int'(ins[15:12]);
    a  = int'(ins[11:6]);
    b  = int'(ins[5:0]);
    exp_q.delete();
    rdy_q.delete();
    sok_q.delete();
    rnd = 1'($urandom_range(0, 1));
    if (!((op == 3 || op == 4) && a < NREG && b < NREG)) begin
      push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), rnd, 0);
      push('0, rnd, 0);
      return;
    end
    oa = 4'(1 << a);
    ob = 4'(1 << b);
    to = 0;
    nw = w;
`ifdef LS_TIMEOUT_EN
    if (w >= TIMEOUT) begin
      to = 1;
      nw = TIMEOUT;
    end
`endif
    push(mk(1, ob, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), rnd, 1);
    push(mk(0, ob, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), rnd, 1);
    if (op == 4) begin
      push(mk(0, oa, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), rnd, 1);
      for (int i = 0; i < nw; i++)
        push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 0, 1);
      if (!to)
        push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1, 1);
    end else begin
      for (int i = 0; i < nw; i++)
        push(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), 0, 1);
      if (!to) begin
        push(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), 1, 1);
        push(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0), rnd, 1);
        push(mk(0, 0, oa, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), rnd, 1);
      end
    end
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, to), rnd, 1);
    push('0, rnd, 0);
  endtask

  task automatic run(
    input logic [15:0] ins,
    input int          w,
    input string       tag
  );
    plan(ins, w);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.instr     = ins;
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    foreach (exp_q[i]) begin
      bus.mem_ready = rdy_q[i];
      bus.start = sok_q[i] ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.instr = 16'($urandom);
      @(negedge clk);
      chk(tag, 32'(obs()), 32'(exp_q[i]));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 32'(obs()), 32'h0);
    rst = 1'b1;

    run(16'h4082, 0, "store_g2");
    run(16'h3043, 3, "load_wait3");
    run(16'h7082, 0, "ill_op");
    run(16'h4141, 0, "ill_field");
    run(16'h3041, 0, "load_same");

    // reset while a load waits on memory
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.instr     = 16'h3043;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ld_rd_wait", 32'(bus.mem_en), 32'h1);
    #2 rst = 1'b0;
    #1 chk("rst_async", 32'(obs()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", 32'(obs()), 32'h0);
    run(16'h4000, 1, "after_rst");

`ifdef LS_TIMEOUT_EN
    run(16'h3043, TIMEOUT - 1, "to_ready_wins");
    run(16'h3043, TIMEOUT, "to_load");
    run(16'h40c1, 40, "to_store");
`else
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.instr     = 16'h3043;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("no_to_busy", 32'(bus.busy), 32'h1);
    chk("no_to_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif

    for (int t = 0; t < 40; t++) begin
      int sel, op, a, b, w;
      sel = int'($urandom_range(0, 9));
      op  = sel < 4 ? 3 : sel < 8 ? 4
          : int'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0)
          ? int'($urandom_range(0, 63))
          : int'($urandom_range(0, NREG - 1));
      b = ($urandom_range(0, 7) == 0)
          ? int'($urandom_range(0, 63))
          : int'($urandom_range(0, NREG - 1));
      w = int'($urandom_range(0, 4));
`ifdef LS_TIMEOUT_EN
      if ($urandom_range(0, 5) == 0)
        w = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
`endif
      run({4'(op), 6'(a), 6'(b)}, w, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
